// File: rtl/npu_result_collector.sv
// npu_result_collector: collects NUM_CLASSES score bytes from the NPU stream and publishes argmax plus status words.
module npu_result_collector #(
  parameter int NUM_CLASSES = 10,
  parameter int SKIP_BYTES  = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  d_in,
  input  logic        d_valid,
  output logic        busy,
  output logic [31:0] ready,
  output logic [31:0] answer
);
  typedef enum logic [1:0] {IDLE, SKIP, COLLECT, DONE} state_t;
  localparam logic [7:0] LAST_CLASS = 8'(NUM_CLASSES - 1);
  localparam logic [7:0] LAST_SKIP  = 8'(SKIP_BYTES - 1);
  localparam state_t     ENTRY      = (SKIP_BYTES > 0) ? SKIP : COLLECT;
  state_t     state;
  logic [7:0] cnt, skip_cnt, max_score, max_idx;
  logic       done, overrun;
  assign ready  = {30'd0, overrun, done};
  assign answer = {8'd0, cnt, max_score, max_idx};
  // start has priority over any byte presented in the same cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      cnt       <= 8'd0;
      skip_cnt  <= 8'd0;
      max_score <= 8'd0;
      max_idx   <= 8'd0;
      done      <= 1'b0;
      overrun   <= 1'b0;
    end else if (start) begin
      state     <= ENTRY;
      busy      <= 1'b1;
      cnt       <= 8'd0;
      skip_cnt  <= 8'd0;
      max_score <= 8'd0;
      max_idx   <= 8'd0;
      done      <= 1'b0;
      overrun   <= 1'b0;
    end else if (d_valid) begin
      case (state)
        SKIP: begin
          skip_cnt <= skip_cnt + 8'd1;
          if (skip_cnt == LAST_SKIP) state <= COLLECT;
        end
        COLLECT: begin
          if (cnt == 8'd0 || d_in > max_score) begin
            max_score <= d_in;
            max_idx   <= cnt;
          end
          cnt <= cnt + 8'd1;
          if (cnt == LAST_CLASS) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        DONE:    overrun <= 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_npu_result_collector.sv
// tb_npu_result_collector: table-driven check of argmax collection, skip, overrun, restart and async reset.
module tb_npu_result_collector;
  logic        clk = 1'b0, reset = 1'b0;
  logic        start0 = 1'b0, dv0 = 1'b0, start2 = 1'b0, dv2 = 1'b0;
  logic [7:0]  d0 = 8'd0, d2 = 8'd0;
  logic        busy0, busy2;
  logic [31:0] ready0, answer0, ready2, answer2;
  int          checks = 0, failures = 0;

  typedef struct {
    logic        sel;
    logic        st;
    logic        dv;
    logic [7:0]  d;
    logic        eb;
    logic [1:0]  er;
    logic [31:0] ea;
  } vec_t;
  vec_t v[$];

  npu_result_collector #(.NUM_CLASSES(10), .SKIP_BYTES(0)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .d_in(d0), .d_valid(dv0),
    .busy(busy0), .ready(ready0), .answer(answer0));
  npu_result_collector #(.NUM_CLASSES(10), .SKIP_BYTES(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .d_in(d2), .d_valid(dv2),
    .busy(busy2), .ready(ready2), .answer(answer2));

  always #5 clk = ~clk;

  function automatic void chk(string n, int i, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s #%0d got=%h want=%h", n, i, got, exp);
    end
  endfunction

  function automatic void add(logic sel, logic st, logic dv, logic [7:0] d, logic eb, logic [1:0] er, logic [31:0] ea);
    v.push_back('{sel, st, dv, d, eb, er, ea});
  endfunction

  task automatic step(input int i, input vec_t x);
    start0 = x.st && !x.sel;
    dv0    = x.dv && !x.sel;
    d0     = x.d;
    start2 = x.st && x.sel;
    dv2    = x.dv && x.sel;
    d2     = x.d;
    @(posedge clk);
    #1;
    chk("busy", i, 32'(x.sel ? busy2 : busy0), 32'(x.eb));
    chk("ready", i, x.sel ? ready2 : ready0, {30'd0, x.er});
    chk("answer", i, x.sel ? answer2 : answer0, x.ea);
    start0 = 1'b0; dv0 = 1'b0; start2 = 1'b0; dv2 = 1'b0;
  endtask

  initial begin
    vec_t r;
    // sel st dv d busy ready answer
    add(0, 0, 1, 8'h55, 0, 0, 32'h0);
    add(0, 1, 0, 8'h00, 1, 0, 32'h0);
    add(0, 0, 1, 8'd3, 1, 0, 32'h00010300);
    add(0, 0, 1, 8'd7, 1, 0, 32'h00020701);
    add(0, 0, 1, 8'd1, 1, 0, 32'h00030701);
    add(0, 0, 1, 8'd9, 1, 0, 32'h00040903);
    add(0, 0, 0, 8'd0, 1, 0, 32'h00040903);
    add(0, 0, 1, 8'd2, 1, 0, 32'h00050903);
    add(0, 0, 1, 8'd9, 1, 0, 32'h00060903);
    add(0, 0, 1, 8'd0, 1, 0, 32'h00070903);
    add(0, 0, 1, 8'd4, 1, 0, 32'h00080903);
    add(0, 0, 1, 8'd5, 1, 0, 32'h00090903);
    add(0, 0, 1, 8'd6, 0, 1, 32'h000A0903);
    add(0, 0, 0, 8'd0, 0, 1, 32'h000A0903);
    add(0, 0, 1, 8'h80, 0, 3, 32'h000A0903);
    add(0, 0, 0, 8'd0, 0, 3, 32'h000A0903);
    add(0, 1, 0, 8'd0, 1, 0, 32'h0);
    add(0, 0, 1, 8'h10, 1, 0, 32'h00011000);
    add(0, 0, 1, 8'h30, 1, 0, 32'h00023001);
    add(0, 0, 1, 8'h50, 1, 0, 32'h00035002);
    add(0, 0, 1, 8'h40, 1, 0, 32'h00045002);
    add(0, 1, 0, 8'd0, 1, 0, 32'h0);
    for (int k = 1; k <= 9; k++) add(0, 0, 1, 8'(k), 1, 0, {8'd0, 8'(k), 8'(k), 8'(k - 1)});
    add(0, 0, 1, 8'h20, 0, 1, 32'h000A2009);
    add(0, 1, 1, 8'hFE, 1, 0, 32'h0);
    for (int k = 1; k <= 9; k++) add(0, 0, 1, 8'h01, 1, 0, {8'd0, 8'(k), 16'h0100});
    add(0, 0, 1, 8'h01, 0, 1, 32'h000A0100);
    add(1, 1, 0, 8'd0, 1, 0, 32'h0);
    add(1, 0, 1, 8'hFF, 1, 0, 32'h0);
    add(1, 0, 1, 8'hFF, 1, 0, 32'h0);
    for (int k = 1; k <= 9; k++) add(1, 0, 1, 8'h00, 1, 0, {8'd0, 8'(k), 16'h0000});
    add(1, 0, 1, 8'h00, 0, 1, 32'h000A0000);
    add(0, 1, 0, 8'd0, 1, 0, 32'h0);
    for (int k = 1; k <= 6; k++) add(0, 0, 1, 8'(k), 1, 0, {8'd0, 8'(k), 8'(k), 8'(k - 1)});

    #1 reset = 1'b1;
    #1;
    chk("rst_busy", 0, 32'(busy0), 32'd0);
    chk("rst_ready", 0, ready0, 32'd0);
    chk("rst_answer", 0, answer0, 32'd0);
    chk("rst_ready2", 0, ready2, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    foreach (v[i]) step(i, v[i]);

    #3 reset = 1'b1;
    #1;
    chk("async_busy", 0, 32'(busy0), 32'd0);
    chk("async_ready", 0, ready0, 32'd0);
    chk("async_answer", 0, answer0, 32'd0);
    chk("async_answer2", 0, answer2, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    r = '{1'b0, 1'b0, 1'b1, 8'hAA, 1'b0, 2'd0, 32'h0};
    for (int k = 0; k < 3; k++) step(200 + k, r);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
